mips_exec_sequencer: RTL
========================

Name: mips_exec_sequencer

Overview:
Multi-cycle controller that runs a short program through the existing combinational MIPS core datapath (instruction, rs value, rt value in; result out). Owns the 32x32 register file, fetches from a synchronous instruction ROM, reads operands, presents them to the core, and writes the result back. Sits between the bench/top level and mips_core_testbench, replacing the one-shot hex read/write flow with a clocked fetch-execute loop.

Parameters:
PROG_LEN, 16, number of instruction words executed before automatic halt (1..256)
ADDR_W, 8, instruction address width (word index)
HALT_OPC, 6'h3F, opcode treated as an explicit halt; not executed, not counted

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins execution at pc=0 when in IDLE, ignored otherwise
busy  out  1  high from the cycle after start is accepted until DONE is entered
done  out  1  one-cycle pulse on entering DONE
imem_addr  out  ADDR_W  instruction word address
imem_rdata  in  32  instruction word, valid one cycle after imem_addr
core_instr  out  32  instruction to the datapath
core_rs  out  32  rs operand to the datapath
core_rt  out  32  rt operand to the datapath
core_result  in  32  combinational datapath result
reg_we  in  1  external register preload write, honoured only in IDLE/DONE
reg_waddr  in  5  preload address
reg_wdata  in  32  preload data
dbg_raddr  in  5  debug read address
dbg_rdata  out  32  combinational register file read, $0 always reads 0
retired  out  16  count of instructions written back since last start

Behaviour:
- Reset: state IDLE, pc=0, busy=0, done=0, imem_addr=0, core_instr/core_rs/core_rt=0, retired=0, all registers cleared to 0. Reset mid-program aborts immediately; no partial writeback survives.
- States: IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH ... -> DONE -> IDLE.
- IDLE: start=1 -> FETCH, pc=0, retired=0, busy=1.
- FETCH (1 cycle): drive imem_addr=pc.
- DECODE (1 cycle): latch imem_rdata into instr register. If opcode==HALT_OPC -> DONE. Else latch core_rs=R[instr[25:21]], core_rt=R[instr[20:16]], core_instr=instr.
- EXEC (1 cycle): operands held stable so the combinational core settles; result sampled at end of cycle into res register.
- WB (1 cycle): destination = instr[15:11] if opcode==0 else instr[20:16]; write res unless destination==0. retired+1 (saturating at 16'hFFFF). pc+1; if new pc==PROG_LEN -> DONE else FETCH.
- Latency: exactly 4 cycles per instruction; a program of N non-halt instructions with no HALT asserts done 4N+1 cycles after the start edge (incl. DONE entry).
- DONE: done=1 for that one cycle, busy=0; next cycle -> IDLE. start in DONE ignored.
- Operand forwarding not needed: WB completes before the next DECODE reads the file.
- Preload: reg_we in IDLE/DONE writes R[reg_waddr]=reg_wdata on clk edge; writes to $0 dropped; reg_we while busy ignored. Preload coincident with start in IDLE: write takes effect; first DECODE sees it.
- pc wraps never: halts at PROG_LEN; PROG_LEN=2^ADDR_W halts when pc would wrap to 0.
- Core outputs retain last values while IDLE/DONE.

Decomposition:
- Shared package mips_pkg: opcode/funct constants (OPC_RTYPE=0, HALT opcode), field slice positions (RS_MSB.., RD, SHAMT, FUNCT), state enum {IDLE,FETCH,DECODE,EXEC,WB,DONE}.
- One sub-module: mips_regfile (32x32, one sync write port with $0 guard, three combinational read ports: rs, rt, dbg). Sequencer muxes preload vs WB onto its write port.

Test Plan:
- Reset mid-EXEC: assert rst_n=0 -> busy=0, state IDLE, all registers read 0 via dbg, retired=0.
- Preload R11=32'hFFFF_FF00, ROM[0]=32'h000B_6043 (sra $12,$11,1), PROG_LEN=1, start -> core_rt=32'hFFFF_FF00 during EXEC, R12=32'hFFFF_FF80, done at cycle 5, retired=1.
- I-type writeback: preload R1=5, ROM[0]=addi $2,$1,7 (32'h2022_0007) -> R2=12, rd field ignored.
- Write to $0: ROM[0]=32'h2000_0009 (addi $0,$0,9) -> dbg_rdata($0)=0, retired=1.
- Dependent chain: ROM addi $1,$0,3; add $2,$1,$1; add $3,$2,$1 -> R3=9, done at 4*3+1=13 cycles.
- HALT at ROM[2] with PROG_LEN=16 -> done after 2 instructions, retired=2, reg_we during busy has no effect, start during DONE ignored.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared instruction-field positions, opcodes and sequencer states.
// No ports; imported by mips_regfile and mips_exec_sequencer.
package mips_pkg;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_HALT  = 6'h3F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WB,
    ST_DONE
  } state_e;

endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, one sync write port, three comb reads.
// Ports: clk, rst_n, we/waddr/wdata, rs/rt/dbg addr in, rs/rt/dbg data out.
module mips_regfile
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] dbg_data
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != 5'd0)) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // $0 is hardwired even though its storage is never written.
  assign rs_data  = (rs_addr  == 5'd0) ? '0 : regs_q[rs_addr];
  assign rt_data  = (rt_addr  == 5'd0) ? '0 : regs_q[rt_addr];
  assign dbg_data = (dbg_addr == 5'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/mips_exec_sequencer.sv
// mips_exec_sequencer: fetch/decode/exec/writeback loop around a comb core.
// Ports: start/busy/done, imem addr/data, core operands/result, preload, dbg.
module mips_exec_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned PROG_LEN = 16,
  parameter int unsigned ADDR_W   = 8,
  parameter logic [5:0]  HALT_OPC = OPC_HALT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       core_instr,
  output logic [31:0]       core_rs,
  output logic [31:0]       core_rt,
  input  logic [31:0]       core_result,
  input  logic              reg_we,
  input  logic [4:0]        reg_waddr,
  input  logic [31:0]       reg_wdata,
  input  logic [4:0]        dbg_raddr,
  output logic [31:0]       dbg_rdata,
  output logic [15:0]       retired
);

  // One extra bit so PROG_LEN == 2^ADDR_W is reachable.
  localparam logic [ADDR_W:0] PROG_END = (ADDR_W + 1)'(PROG_LEN);
  localparam logic [ADDR_W:0] PC_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       cinstr_q, cinstr_d;
  logic [31:0]       crs_q, crs_d;
  logic [31:0]       crt_q, crt_d;
  logic [31:0]       res_q, res_d;
  logic [15:0]       retired_q, retired_d;

  logic [ADDR_W:0]   pc_inc;
  logic [4:0]        wb_dest;
  logic              rf_we;
  logic [4:0]        rf_waddr;
  logic [31:0]       rf_wdata;
  logic [31:0]       rf_rs;
  logic [31:0]       rf_rt;

  assign pc_inc = {1'b0, pc_q} + PC_ONE;

  // cinstr_q doubles as the instruction register for writeback.
  assign wb_dest =
    (cinstr_q[OPC_MSB:OPC_LSB] == OPC_RTYPE)
      ? cinstr_q[RD_MSB:RD_LSB]
      : cinstr_q[RT_MSB:RT_LSB];

  mips_regfile u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .rs_addr  (imem_rdata[RS_MSB:RS_LSB]),
    .rt_addr  (imem_rdata[RT_MSB:RT_LSB]),
    .dbg_addr (dbg_raddr),
    .rs_data  (rf_rs),
    .rt_data  (rf_rt),
    .dbg_data (dbg_rdata)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cinstr_d  = cinstr_q;
    crs_d     = crs_q;
    crt_d     = crt_q;
    res_d     = res_q;
    retired_d = retired_q;
    rf_we     = 1'b0;
    rf_waddr  = reg_waddr;
    rf_wdata  = reg_wdata;
    unique case (state_q)
      ST_IDLE: begin
        rf_we = reg_we;
        if (start) begin
          state_d   = ST_FETCH;
          pc_d      = '0;
          retired_d = '0;
        end
      end
      ST_FETCH: begin
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (imem_rdata[OPC_MSB:OPC_LSB] == HALT_OPC) begin
          state_d = ST_DONE;
        end else begin
          cinstr_d = imem_rdata;
          crs_d    = rf_rs;
          crt_d    = rf_rt;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = core_result;
        state_d = ST_WB;
      end
      ST_WB: begin
        rf_we    = (wb_dest != 5'd0);
        rf_waddr = wb_dest;
        rf_wdata = res_q;
        if (retired_q != 16'hFFFF) begin
          retired_d = retired_q + 16'd1;
        end
        pc_d    = pc_inc[ADDR_W-1:0];
        state_d = (pc_inc == PROG_END) ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        rf_we   = reg_we;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      cinstr_q  <= '0;
      crs_q     <= '0;
      crt_q     <= '0;
      res_q     <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cinstr_q  <= cinstr_d;
      crs_q     <= crs_d;
      crt_q     <= crt_d;
      res_q     <= res_d;
      retired_q <= retired_d;
    end
  end

  assign busy = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                (state_q == ST_EXEC)  || (state_q == ST_WB);
  assign done       = (state_q == ST_DONE);
  assign imem_addr  = pc_q;
  assign core_instr = cinstr_q;
  assign core_rs    = crs_q;
  assign core_rt    = crt_q;
  assign retired    = retired_q;

endmodule
